// File: rtl/mips_top_core.sv
// Three-stage (IF/ID/EX) PC-only MIPS pipeline with one external interrupt and a
// four-instruction handler at 0x80-0x83; LED shows EPC, retire count or interrupt count.
module mips_top_core (
    input  logic       CCLK,
    input  logic       BTNN,
    input  logic [3:0] SW,
    input  logic       BTNW,
    input  logic       BTNE,
    input  logic       BTNS,
    input  logic       ROTA,
    input  logic       ROTB,
    input  logic       ROTCTR,
    output logic [7:0] LED,
    output logic       LCDE,
    output logic       LCDRS,
    output logic       LCDRW,
    output logic [3:0] LCDDAT
);
    localparam logic [7:0] PC_HANDLER = 8'h80;
    localparam logic [7:0] PC_ERET    = 8'h83;

    typedef enum logic {MODE_USER = 1'b0, MODE_IRQ = 1'b1} mode_e;
    mode_e mode_q, mode_d;

    logic [7:0]  pc_q, pc_d;
    logic        vld_p0_q, vld_p1_q, vld_p2_q;
    logic        vld_p0_d, vld_p1_d;
    logic [7:0]  pc_p0_q, pc_p1_q, pc_p2_q;
    logic        ie_q, ie_d;
    logic        pend_q, pend_d;
    logic [2:0]  sync_q;
    logic [6:0]  epc_q, epc_d;
    logic [7:0]  icount_q, icount_d;
    logic [15:0] rmain_q, rmain_d;
    logic        btnw_rise, take_irq, do_eret, retire_user, exec_handler;

    // Instruction effects commit on the edge the ID instruction is latched into EX,
    // so the EX register records the instruction that has just executed.
    logic unused_sink;
    assign unused_sink = ^{BTNE, BTNS, ROTA, ROTB, ROTCTR, SW[3:2], rmain_q[15:8],
                           vld_p2_q, pc_p2_q};

    assign btnw_rise = sync_q[1] & ~sync_q[2];

    always_ff @(posedge CCLK or negedge BTNN) begin
        if (!BTNN) begin
            mode_q <= MODE_USER;
        end else begin
            mode_q <= mode_d;
        end
    end

    always_comb begin
        mode_d = mode_q;
        if (mode_q == MODE_USER) begin
            if (take_irq) mode_d = MODE_IRQ;
        end else begin
            if (do_eret) mode_d = MODE_USER;
        end
    end

    always_comb begin
        take_irq = 1'b0;
        do_eret  = 1'b0;
        if (mode_q == MODE_USER) begin
            take_irq = vld_p1_q & pend_q & ie_q & ~pc_p1_q[7];
        end else begin
            do_eret  = vld_p1_q & (pc_p1_q == PC_ERET);
        end
    end

    always_comb begin
        retire_user  = vld_p1_q & ~pc_p1_q[7];
        exec_handler = vld_p1_q & (pc_p1_q == PC_HANDLER);
        rmain_d      = rmain_q + {15'd0, retire_user};
        icount_d     = icount_q + {7'd0, exec_handler};
        pend_d       = take_irq ? 1'b0 : (pend_q | btnw_rise);
        ie_d         = ie_q;
        epc_d        = epc_q;
        vld_p0_d     = 1'b1;
        vld_p1_d     = vld_p0_q;
        // User PC wraps inside 0x00-0x7F; handler PC simply counts upward.
        pc_d         = pc_q[7] ? (pc_q + 8'd1) : {1'b0, pc_q[6:0] + 7'd1};
        if (take_irq) begin
            ie_d     = 1'b0;
            epc_d    = pc_p1_q[6:0] + 7'd1;
            pc_d     = PC_HANDLER;
            vld_p0_d = 1'b0;
            vld_p1_d = 1'b0;
        end else if (do_eret) begin
            ie_d     = 1'b1;
            pc_d     = {1'b0, epc_q};
            vld_p0_d = 1'b0;
            vld_p1_d = 1'b0;
        end
    end

    always_ff @(posedge CCLK or negedge BTNN) begin
        if (!BTNN) begin
            sync_q   <= 3'b000;
            pc_q     <= 8'h00;
            vld_p0_q <= 1'b0;
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            pc_p0_q  <= 8'h00;
            pc_p1_q  <= 8'h00;
            pc_p2_q  <= 8'h00;
            ie_q     <= 1'b1;
            pend_q   <= 1'b0;
            epc_q    <= 7'd0;
            icount_q <= 8'd0;
            rmain_q  <= 16'd0;
        end else begin
            sync_q   <= {sync_q[1], sync_q[0], BTNW};
            pc_q     <= pc_d;
            vld_p0_q <= vld_p0_d;
            pc_p0_q  <= pc_q;
            vld_p1_q <= vld_p1_d;
            pc_p1_q  <= pc_p0_q;
            vld_p2_q <= vld_p1_q;
            pc_p2_q  <= pc_p1_q;
            ie_q     <= ie_d;
            pend_q   <= pend_d;
            epc_q    <= epc_d;
            icount_q <= icount_d;
            rmain_q  <= rmain_d;
        end
    end

    always_comb begin
        if (SW[1]) begin
            LED = {1'b0, epc_q};
        end else if (SW[0]) begin
            LED = rmain_q[7:0];
        end else begin
            LED = icount_q;
        end
    end

    assign LCDE   = 1'b0;
    assign LCDRS  = 1'b0;
    assign LCDRW  = 1'b0;
    assign LCDDAT = 4'h0;
endmodule

// File: tb/tb_mips_top_core.sv
// Bench for mips_top_core: queue-based reference model of fetch/execute plus
// directed timeline and randomized interrupt pulses and resets.
module tb_mips_top_core;
    logic       CCLK = 1'b0;
    logic       BTNN;
    logic       BTNW;
    logic [3:0] SW;
    logic       BTNE = 1'b0, BTNS = 1'b0, ROTA = 1'b0, ROTB = 1'b0, ROTCTR = 1'b0;
    logic [7:0] LED;
    logic       LCDE, LCDRS, LCDRW;
    logic [3:0] LCDDAT;

    int n_chk  = 0;
    int n_fail = 0;
    logic [7:0] obs [3];

    always #20 CCLK = ~CCLK;

    mips_top_core dut (
        .CCLK(CCLK), .BTNN(BTNN), .SW(SW), .BTNW(BTNW), .BTNE(BTNE), .BTNS(BTNS),
        .ROTA(ROTA), .ROTB(ROTB), .ROTCTR(ROTCTR), .LED(LED), .LCDE(LCDE),
        .LCDRS(LCDRS), .LCDRW(LCDRW), .LCDDAT(LCDDAT)
    );

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: an instruction executes two edges after it is fetched,
    // unless a redirect (interrupt entry or ERET) discards the in-flight fetches.
    logic [7:0]  m_pc, m_epc, m_ic, xpc;
    logic [15:0] m_rm;
    logic        m_irq, m_pend, w1, w2, w3, rise, xv, take, eret;
    logic [7:0]  m_q [$];

    always @(posedge CCLK or negedge BTNN) begin
        if (!BTNN) begin
            m_pc = 8'h00; m_epc = 8'h00; m_ic = 8'h00; m_rm = 16'h0000;
            m_irq = 1'b0; m_pend = 1'b0; w1 = 1'b0; w2 = 1'b0; w3 = 1'b0;
            m_q.delete();
        end else begin
            rise = w2 & ~w3;
            w3 = w2; w2 = w1; w1 = BTNW;
            xv = (m_q.size() == 2);
            xpc = 8'h00;
            if (xv) xpc = m_q.pop_front();
            take = xv && m_pend && !m_irq && (xpc < 8'h80);
            eret = xv && m_irq && (xpc == 8'h83);
            if (xv && xpc < 8'h80) m_rm = m_rm + 16'd1;
            if (xv && xpc == 8'h80) m_ic = m_ic + 8'd1;
            m_pend = take ? 1'b0 : (m_pend | rise);
            if (take) begin
                m_epc = (xpc + 8'd1) & 8'h7F;
                m_irq = 1'b1;
                m_q.delete();
                m_pc = 8'h80;
            end else if (eret) begin
                m_irq = 1'b0;
                m_q.delete();
                m_pc = m_epc;
            end else begin
                m_q.push_back(m_pc);
                m_pc = m_irq ? (m_pc + 8'd1) : ((m_pc + 8'd1) & 8'h7F);
            end
        end
    end

    // Every cycle: walk all three LED views and compare against the model.
    always @(negedge CCLK) begin : cmp
        logic [1:0] hi;
        logic [7:0] exp;
        for (int s = 0; s < 3; s++) begin
            hi = 2'($urandom);
            case (s)
                0:       SW = {hi, 2'b00};
                1:       SW = {hi, 2'b01};
                default: SW = {hi, 1'b1, hi[0]};
            endcase
            #1;
            case (s)
                0:       exp = m_ic;
                1:       exp = m_rm[7:0];
                default: exp = m_epc;
            endcase
            check($sformatf("led_view%0d", s), LED, exp);
            obs[s] = LED;
        end
        check("lcd_const", {LCDE, LCDRS, LCDRW, 1'b0, LCDDAT}, 8'h00);
    end

    task automatic step(input logic w);
        @(posedge CCLK);
        @(negedge CCLK);
        #5 BTNW = w;
        #1;
    endtask

    task automatic do_reset(input int hold);
        @(negedge CCLK);
        #10 BTNN = 1'b0;
        #1 check("async_reset_led", LED, 8'h00);
        for (int i = 0; i < hold; i++) begin
            @(negedge CCLK);
            #5 BTNW = 1'($urandom);
        end
        @(negedge CCLK);
        #5 BTNW = 1'b0;
        #5 BTNN = 1'b1;
    endtask

    initial begin
        BTNN = 1'b0;
        BTNW = 1'b0;
        repeat (3) @(negedge CCLK);
        #6 check("reset_led", LED, 8'h00);
        #4 BTNN = 1'b1;

        // Pulses sampled on edges 127-131 and 134-138 after release.
        for (int k = 1; k <= 143; k++) begin
            step(((k + 1 >= 127) && (k + 1 <= 131)) || ((k + 1 >= 134) && (k + 1 <= 138)));
            if (k == 10) begin
                check("pin_rmain_10", obs[1], 8'h08);
                check("pin_icount_10", obs[0], 8'h00);
            end
            if (k == 135) begin
                check("pin_epc_wrap", obs[2], 8'h00);
                check("pin_icount_135", obs[0], 8'h01);
                check("pin_rmain_135", obs[1], 8'h80);
            end
            if (k == 142) begin
                check("pin_icount_142", obs[0], 8'h02);
                check("pin_epc_142", obs[2], 8'h01);
                check("pin_rmain_142", obs[1], 8'h81);
            end
        end
        // Reset during handler instruction 0x81.
        #4 BTNN = 1'b0;
        #1 check("reset_in_handler", LED, 8'h00);
        for (int i = 0; i < 3; i++) begin
            @(negedge CCLK);
            #5 BTNW = 1'($urandom);
        end
        @(negedge CCLK);
        #5 BTNW = 1'b0;
        #5 BTNN = 1'b1;
        repeat (10) step(1'b0);
        check("pin_rmain_after_rst", obs[1], 8'h08);
        check("pin_icount_after_rst", obs[0], 8'h00);
        check("pin_epc_after_rst", obs[2], 8'h00);

        for (int p = 0; p < 6; p++) begin
            repeat ($urandom_range(50, 125)) step(1'b0);
            repeat (5) step(1'b1);
        end
        repeat (30) step(1'b0);
        check("pin_icount_six", obs[0], 8'h06);

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(1, 60)) step(1'b0);
            repeat ($urandom_range(1, 8)) step(1'b1);
            if (i % 10 == 9) do_reset(int'($urandom_range(1, 4)));
        end
        repeat (20) step(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
